// File: rtl/rns_pkg.sv
// Shared definitions for the RNS FIR datapath.
//   RNS_B0..RNS_B3 : lane moduli (product 3368562317, CRT-compatible)
//   rns_t          : four packed 8-bit residues, lane 3 in the MSB
//   fir_state_t    : MAC sequencer states
package rns_pkg;

  localparam int unsigned RNS_B0 = 251;
  localparam int unsigned RNS_B1 = 241;
  localparam int unsigned RNS_B2 = 239;
  localparam int unsigned RNS_B3 = 233;
  localparam int unsigned RES_W  = 8;

  typedef struct packed {
    logic [RES_W-1:0] r3;
    logic [RES_W-1:0] r2;
    logic [RES_W-1:0] r1;
    logic [RES_W-1:0] r0;
  } rns_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_t;

endpackage

// File: rtl/rns_mac_lane.sv
// One residue lane of the MAC: mac_o = (acc_i + (a_i * b_i) mod M) mod M.
// Purely combinational.
//   acc_i : running accumulator residue, always < M
//   a_i   : sample residue (values >= M are legal)
//   b_i   : coefficient residue (values >= M are legal)
//   mac_o : updated accumulator residue, < M
module rns_mac_lane #(
  parameter int unsigned M = 251
) (
  input  logic [7:0] acc_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] mac_o
);

  logic [15:0] prod;
  logic [7:0]  prod_mod;
  logic [8:0]  sum;

  // Full reduction of the raw product handles unreduced inputs correctly.
  assign prod     = 16'(a_i) * 16'(b_i);
  assign prod_mod = 8'(prod % 16'(M));

  // Both addends are < M, so one conditional subtract is enough.
  assign sum   = 9'(acc_i) + 9'(prod_mod);
  assign mac_o = (sum >= 9'(M)) ? 8'(sum - 9'(M)) : sum[7:0];

endmodule

// File: rtl/rns_fir_mac.sv
// Sequential RNS FIR stage: a TAPS-deep sample delay line and coefficient
// bank, walked one tap per cycle with a residue-wise multiply-accumulate.
// Optional feature macro: RNS_FIR_COEF_RDBACK_EN adds coef_rdata.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/valid/ready  : RNS sample input handshake
//   coef_we/addr/data : coefficient write port (honoured in IDLE only)
//   out_data/valid/ready : RNS filter result handshake
//   coef_rdata        : (optional) combinational read of c[coef_addr]
module rns_fir_mac
  import rns_pkg::*;
#(
  parameter int unsigned B0   = RNS_B0,
  parameter int unsigned B1   = RNS_B1,
  parameter int unsigned B2   = RNS_B2,
  parameter int unsigned B3   = RNS_B3,
  parameter int unsigned TAPS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [31:0]             coef_data,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef RNS_FIR_COEF_RDBACK_EN
  ,
  output logic [31:0]             coef_rdata
`endif
);

  localparam int unsigned TAPW = $clog2(TAPS);

  fir_state_t      state_q;
  rns_t            d_q [TAPS];
  rns_t            c_q [TAPS];
  rns_t            acc_q;
  rns_t            acc_d;
  logic [TAPW-1:0] tap_q;
  logic            out_valid_q;
  rns_t            d_sel;
  rns_t            c_sel;
  logic            coef_addr_ok;

  assign d_sel        = d_q[tap_q];
  assign c_sel        = c_q[tap_q];
  assign coef_addr_ok = 32'(coef_addr) < TAPS;

  // One MAC lane per modulus.
  rns_mac_lane #(.M(B0)) u_lane0 (.acc_i(acc_q.r0), .a_i(d_sel.r0), .b_i(c_sel.r0), .mac_o(acc_d.r0));
  rns_mac_lane #(.M(B1)) u_lane1 (.acc_i(acc_q.r1), .a_i(d_sel.r1), .b_i(c_sel.r1), .mac_o(acc_d.r1));
  rns_mac_lane #(.M(B2)) u_lane2 (.acc_i(acc_q.r2), .a_i(d_sel.r2), .b_i(c_sel.r2), .mac_o(acc_d.r2));
  rns_mac_lane #(.M(B3)) u_lane3 (.acc_i(acc_q.r3), .a_i(d_sel.r3), .b_i(c_sel.r3), .mac_o(acc_d.r3));

  // Sequencer, storage and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        d_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (coef_we && coef_addr_ok) begin
            c_q[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            for (int unsigned k = 1; k < TAPS; k++) begin
              d_q[k] <= d_q[k-1];
            end
            d_q[0]  <= in_data;
            acc_q   <= '0;
            tap_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + TAPW'(1);
          if (tap_q == TAPW'(TAPS - 1)) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so it is low throughout reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

`ifdef RNS_FIR_COEF_RDBACK_EN
  assign coef_rdata = coef_addr_ok ? c_q[coef_addr] : '0;
`endif

endmodule

// File: tb/tb_rns_fir_mac.sv
module tb_rns_fir_mac;

  localparam int unsigned TAPS = 8;
  localparam int unsigned AW   = $clog2(TAPS);

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [31:0]   coef_data;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef RNS_FIR_COEF_RDBACK_EN
  logic [31:0]   coef_rdata;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: raw coefficient and sample words.
  logic [31:0] mc [TAPS];
  logic [31:0] md [TAPS];
  int unsigned mods [4] = '{251, 241, 239, 233};

  rns_fir_mac #(.TAPS(TAPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RNS_FIR_COEF_RDBACK_EN
    ,
    .coef_rdata(coef_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Dot product of delay line and coefficients, per lane, reduced at the end.
  function automatic logic [31:0] model_out();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      longint unsigned s;
      s = 0;
      for (int k = 0; k < int'(TAPS); k++) begin
        longint unsigned a;
        longint unsigned b;
        a = longint'((md[k] >> (8 * i)) & 32'hFF);
        b = longint'((mc[k] >> (8 * i)) & 32'hFF);
        s = s + a * b;
      end
      r = r | (32'(s % longint'(mods[i])) << (8 * i));
    end
    return r;
  endfunction

  function automatic void model_shift(input logic [31:0] s);
    for (int k = int'(TAPS) - 1; k > 0; k--) md[k] = md[k-1];
    md[0] = s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < int'(TAPS); k++) begin
      md[k] = '0;
      mc[k] = '0;
    end
  endfunction

  task automatic wcoef(input int addr, input logic [31:0] data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data;
    step();
    coef_we   = 1'b0;
    mc[addr]  = data;
  endtask

  // One full sample transaction with optional output stall and coefficient writes.
  task automatic send(input logic [31:0] s, input int stall, input bit mac_wr,
                      input bit same_wr, input logic [31:0] same_data);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_data  = s;
    in_valid = 1'b1;
    if (same_wr) begin
      coef_we   = 1'b1;
      coef_addr = '0;
      coef_data = same_data;
      mc[0]     = same_data;
    end
    step();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    model_shift(s);
    exp = model_out();
    n = 0;
    while (!out_valid && n < 50) begin
      if (mac_wr && n == 3) begin
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 32'h05050505;
      end
      step();
      coef_we = 1'b0;
      n++;
    end
    chk("latency", 32'(n), 32'(TAPS));
    chk("out_data", out_data, exp);
    chk("in_ready_in_out", 32'(in_ready), 32'd0);
    for (int j = 0; j < stall; j++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, exp);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    model_clear();

    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Impulse response
    for (int k = 0; k < int'(TAPS); k++) wcoef(k, 32'(k + 1) * 32'h01010101);
    send(32'h01010101, 0, 1'b0, 1'b0, '0);
    for (int k = 1; k < int'(TAPS); k++) send(32'h00000000, 0, 1'b0, 1'b0, '0);

    // Modular wrap: (B-1)^2 mod B = 1 in every lane
    for (int k = 0; k < int'(TAPS); k++) wcoef(k, (k == 0) ? 32'hE8EEF0FA : 32'h0);
    send(32'hE8EEF0FA, 0, 1'b0, 1'b0, '0);

    // Random coefficients and samples, including unreduced residues
    for (int k = 0; k < int'(TAPS); k++) wcoef(k, $urandom());
    for (int t = 0; t < 6; t++) send($urandom(), int'($urandom_range(0, 3)), 1'b0, 1'b0, '0);

    // Backpressure with in_valid held during OUT
    send($urandom(), 5, 1'b0, 1'b0, '0);

    // Coefficient write during MAC is dropped; same write in IDLE applies
    wcoef(0, $urandom() | 32'h01010101);
    send($urandom() | 32'h01010101, 0, 1'b1, 1'b0, '0);
    send($urandom(), 0, 1'b0, 1'b0, '0);
    wcoef(0, 32'h05050505);
    send($urandom() | 32'h01010101, 0, 1'b0, 1'b0, '0);

    // Coefficient write and sample accepted on the same edge
    send($urandom() | 32'h01010101, 1, 1'b0, 1'b1, $urandom() | 32'h02020202);

    // Reset in the middle of a MAC pass
    in_data  = $urandom();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_idle", 32'(in_ready), 32'd1);
    model_clear();
    for (int j = 0; j < int'(TAPS) + 2; j++) begin
      step();
      chk("no_partial", 32'(out_valid), 32'd0);
    end
    send($urandom(), 0, 1'b0, 1'b0, '0);

`ifdef RNS_FIR_COEF_RDBACK_EN
    wcoef(3, 32'h0A0B0C0D);
    coef_addr = AW'(3);
    #1;
    chk("rdback_c3", coef_rdata, 32'h0A0B0C0D);
    coef_addr = AW'(1);
    #1;
    chk("rdback_c1", coef_rdata, mc[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
